// File: rtl/gate_ctl_if.sv
// Gate controller bus: frame strobe, request, player position in; gate status out.
interface gate_ctl_if;
    logic        v_tick;
    logic        button_pressed;
    logic [11:0] xpos_player;
    logic        gate_open;
    logic [7:0]  gate_height;
    logic [1:0]  gate_state;

    // Environment side: drives strobe, request and position, observes the gate.
    modport master (
        output v_tick,
        output button_pressed,
        output xpos_player,
        input  gate_open,
        input  gate_height,
        input  gate_state
    );

    // Controller side.
    modport slave (
        input  v_tick,
        input  button_pressed,
        input  xpos_player,
        output gate_open,
        output gate_height,
        output gate_state
    );
endinterface

// File: rtl/gate_ctl.sv
// Gate controller: opens on request, holds open for a frame count, never closes on
// a player standing in the gate zone, and reverses a closing gate on request/occupancy.
// All state advances only on the rising edge of the frame strobe.
module gate_ctl #(
    parameter int unsigned GATE_X_MIN  = 350,
    parameter int unsigned GATE_X_MAX  = 450,
    parameter int unsigned GATE_H      = 100,
    parameter int unsigned STEP        = 4,
    parameter int unsigned HOLD_FRAMES = 120
) (
    input  logic        clk,
    input  logic        rst,
    gate_ctl_if.slave   bus
);

    localparam int unsigned HW = 8;
    localparam int unsigned XW = 12;

    localparam logic [HW-1:0] H_FULL = HW'(GATE_H);
    localparam logic [HW-1:0] H_STEP = HW'(STEP);
    localparam logic [HW-1:0] H_NEAR = HW'(GATE_H - STEP);
    localparam logic [HW-1:0] HOLD_N = HW'(HOLD_FRAMES);
    localparam logic [XW-1:0] X_MIN  = XW'(GATE_X_MIN);
    localparam logic [XW-1:0] X_MAX  = XW'(GATE_X_MAX);

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPENING = 2'd1,
        ST_OPEN    = 2'd2,
        ST_CLOSING = 2'd3
    } state_e;

    state_e        state_q,  state_d;
    logic [HW-1:0] height_q, height_d;
    logic [HW-1:0] hold_q,   hold_d;
    logic          open_q,   open_d;
    logic          v_tick_old_q;

    logic          tick_c;
    logic          in_zone_c;

    // Frame tick is the rising edge of the level strobe.
    assign tick_c    = bus.v_tick & ~v_tick_old_q;
    assign in_zone_c = (bus.xpos_player >= X_MIN) && (bus.xpos_player <= X_MAX);

    // Strobe history, updated every clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_tick_old_q <= 1'b0;
        end else begin
            v_tick_old_q <= bus.v_tick;
        end
    end

    // State, height, hold counter and open flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_CLOSED;
            height_q <= H_FULL;
            hold_q   <= '0;
            open_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            height_q <= height_d;
            hold_q   <= hold_d;
            open_q   <= open_d;
        end
    end

    // Next-state, height and hold counter; everything holds between frame ticks.
    always_comb begin
        state_d  = state_q;
        height_d = height_q;
        hold_d   = hold_q;

        unique case (state_q)
            ST_CLOSED: begin
                if (tick_c && bus.button_pressed) begin
                    state_d = ST_OPENING;
                end
            end

            ST_OPENING: begin
                // Runs to completion; the request is remembered by the state itself.
                if (tick_c) begin
                    if (height_q <= H_STEP) begin
                        height_d = '0;
                        state_d  = ST_OPEN;
                        hold_d   = HOLD_N;
                    end else begin
                        height_d = height_q - H_STEP;
                    end
                end
            end

            ST_OPEN: begin
                if (tick_c) begin
                    if (bus.button_pressed) begin
                        hold_d = HOLD_N;
                    end else if (hold_q != '0) begin
                        hold_d = hold_q - HW'(1);
                    end else if (!in_zone_c) begin
                        state_d = ST_CLOSING;
                    end
                end
            end

            ST_CLOSING: begin
                // Reversal wins over further closing motion.
                if (tick_c) begin
                    if (bus.button_pressed || in_zone_c) begin
                        state_d = ST_OPENING;
                    end else if (height_q >= H_NEAR) begin
                        height_d = H_FULL;
                        state_d  = ST_CLOSED;
                    end else begin
                        height_d = height_q + H_STEP;
                    end
                end
            end

            default: begin
                state_d  = ST_CLOSED;
                height_d = H_FULL;
                hold_d   = '0;
            end
        endcase
    end

    // Open flag tracks the state it will be registered alongside.
    always_comb begin
        open_d = (state_d == ST_OPEN);
    end

    assign bus.gate_open   = open_q;
    assign bus.gate_height = height_q;
    assign bus.gate_state  = state_q;

endmodule

// File: tb/tb_gate_ctl.sv
// Directed bench for gate_ctl with default parameters and hand-computed expectations.
module tb_gate_ctl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    gate_ctl_if bus ();

    gate_ctl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_gate(input string tag, input int st, input int h, input int op);
        check_eq({tag, ".state"},  32'(bus.gate_state),  32'(st));
        check_eq({tag, ".height"}, 32'(bus.gate_height), 32'(h));
        check_eq({tag, ".open"},   32'(bus.gate_open),   32'(op));
    endtask

    // One frame: strobe high for a clock, then low for two; outputs settled on return.
    task automatic do_tick();
        @(negedge clk) bus.v_tick = 1'b1;
        @(negedge clk) bus.v_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst                = 1'b1;
        bus.v_tick         = 1'b0;
        bus.button_pressed = 1'b0;
        bus.xpos_player    = 12'd0;

        // Reset
        repeat (2) @(negedge clk);
        check_gate("reset", 0, 100, 0);
        rst = 1'b0;
        @(negedge clk);
        check_gate("idle", 0, 100, 0);

        // Open sequence: button on tick 1 only
        bus.button_pressed = 1'b1;
        do_tick();
        check_gate("open.t1", 1, 100, 0);
        bus.button_pressed = 1'b0;
        do_tick();
        check_gate("open.t2", 1, 96, 0);
        ticks(23);
        check_gate("open.t25", 1, 4, 0);
        do_tick();
        check_gate("open.t26", 2, 0, 1);

        // Hold then close
        ticks(120);
        check_gate("hold.120", 2, 0, 1);
        do_tick();
        check_gate("hold.121", 3, 0, 0);
        ticks(24);
        check_gate("close.24", 3, 96, 0);
        do_tick();
        check_gate("close.25", 0, 100, 0);

        // Zone block: expired counter with player at x=400
        bus.button_pressed = 1'b1;
        do_tick();
        bus.button_pressed = 1'b0;
        ticks(25);
        check_gate("zone.open", 2, 0, 1);
        bus.xpos_player = 12'd400;
        ticks(120);
        ticks(500);
        check_gate("zone.500", 2, 0, 1);
        bus.xpos_player = 12'd451;
        do_tick();
        check_gate("zone.x451", 3, 0, 0);

        // Reversal at h=40
        ticks(10);
        check_gate("rev.h40", 3, 40, 0);
        bus.button_pressed = 1'b1;
        do_tick();
        check_gate("rev.btn", 1, 40, 0);
        bus.button_pressed = 1'b0;
        do_tick();
        check_gate("rev.next", 1, 36, 0);
        ticks(9);
        check_gate("rev.open", 2, 0, 1);

        // Zone boundaries: x=350 and x=450 reverse a closing gate, x=349 does not
        bus.xpos_player = 12'd0;
        ticks(121);
        do_tick();
        check_gate("bnd.closing", 3, 4, 0);
        bus.xpos_player = 12'd350;
        do_tick();
        check_gate("bnd.x350", 1, 4, 0);
        do_tick();
        check_gate("bnd.reopen", 2, 0, 1);
        bus.xpos_player = 12'd0;
        ticks(121);
        check_gate("bnd.closing2", 3, 0, 0);
        bus.xpos_player = 12'd450;
        do_tick();
        check_gate("bnd.x450", 1, 0, 0);
        do_tick();
        check_gate("bnd.reopen2", 2, 0, 1);
        ticks(120);
        bus.xpos_player = 12'd349;
        do_tick();
        check_gate("bnd.x349a", 3, 0, 0);
        do_tick();
        check_gate("bnd.x349b", 3, 4, 0);

        // Strobe held high for 1000 clocks moves one step only
        bus.xpos_player = 12'd0;
        @(negedge clk) bus.v_tick = 1'b1;
        repeat (1000) @(negedge clk);
        check_gate("long.vtick", 3, 8, 0);
        bus.v_tick = 1'b0;
        @(negedge clk);
        check_gate("long.release", 3, 8, 0);

        // Reset mid-opening at h=60, asserted together with a tick
        ticks(23);
        check_gate("rst.closed", 0, 100, 0);
        bus.button_pressed = 1'b1;
        do_tick();
        bus.button_pressed = 1'b0;
        ticks(10);
        check_gate("rst.h60", 1, 60, 0);
        @(negedge clk);
        rst        = 1'b1;
        bus.v_tick = 1'b1;
        @(negedge clk);
        check_gate("rst.mid", 0, 100, 0);
        rst        = 1'b0;
        bus.v_tick = 1'b0;
        @(negedge clk);
        check_gate("rst.after", 0, 100, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_ctl.md
GATE_CTL -- requirements
Module: gate_ctl

Interface
REQ-001 Parameter GATE_X_MIN, default 350, meaning: left x edge of gate zone (player xpos units).
REQ-002 Parameter GATE_X_MAX, default 450, meaning: right x edge of gate zone, inclusive.
REQ-003 Parameter GATE_H, default 100, meaning: fully closed gate height in pixels (≤255).
REQ-004 Parameter STEP, default 4, meaning: height change per frame while moving (GATE_H multiple of STEP).
REQ-005 Parameter HOLD_FRAMES, default 120, meaning: frames gate stays open after request ends (≤255).
REQ-006 Clocking: one clock; reset synchronous and active-high.
REQ-007 clk  input  1  system clock; all state updates on posedge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 v_tick  input  1  frame strobe; level signal, its rising edge is the frame tick.
REQ-010 button_pressed  input  1  open request, sampled on frame ticks only.
REQ-011 xpos_player  input  12  player x position, unsigned.
REQ-012 gate_open  output  1  gate fully open, player may cross zone; feeds player movement control.
REQ-013 gate_height  output  8  current gate height for drawing, unsigned, 0..GATE_H.
REQ-014 gate_state  output  2  encoded state: CLOSED=0, OPENING=1, OPEN=2, CLOSING=3.

Function
REQ-015 Frame tick SHALL be v_tick==1 while registered v_tick_old==0; v_tick_old SHALL update every clk.
REQ-016 State, gate_height, hold counter SHALL change only on clk edges where frame tick is true; otherwise hold.
REQ-017 All outputs SHALL be registered; gate_open SHALL equal (state==OPEN), updating same edge as state.
REQ-018 in_zone SHALL be GATE_X_MIN ≤ xpos_player ≤ GATE_X_MAX, unsigned compare.
REQ-019 CLOSED: height GATE_H; on tick with button_pressed SHALL go OPENING, height unchanged that tick.
REQ-020 OPENING: each tick height SHALL decrease by STEP, saturating at 0; tick where result is 0 SHALL enter OPEN and load hold counter with HOLD_FRAMES.
REQ-021 OPENING SHALL continue to completion regardless of button_pressed (request latched by state).
REQ-022 OPEN: on tick with button_pressed, hold counter SHALL reload HOLD_FRAMES; else if counter>0 it SHALL decrement.
REQ-023 OPEN: on tick with counter==0, !button_pressed, !in_zone SHALL go CLOSING, height unchanged that tick.
REQ-024 OPEN with counter==0 and in_zone SHALL remain OPEN indefinitely (never close on player).
REQ-025 CLOSING: on tick with button_pressed or in_zone SHALL go OPENING, height unchanged that tick (reversal has priority).
REQ-026 CLOSING otherwise: height SHALL increase by STEP, saturating at GATE_H; tick where result equals GATE_H SHALL enter CLOSED.
REQ-027 Height arithmetic SHALL be 8-bit with explicit saturation; no wrap-around at 0 or GATE_H.
REQ-028 Illegal state encoding SHALL recover to CLOSED with height GATE_H on next clk.
REQ-029 v_tick held high for many clks SHALL produce exactly one tick.

Reset
REQ-030 On rst: state CLOSED, gate_state 0, gate_height GATE_H, gate_open 0, hold counter 0, v_tick_old 0.
REQ-031 rst SHALL take priority over tick in same cycle; reset mid-operation SHALL return to CLOSED on next clk edge, no partial motion retained.

Verification (defaults; tick = one v_tick rising edge)
REQ-032 Reset: assert rst 2 clks -> gate_height=100, gate_open=0, gate_state=0.
REQ-033 Open: x=0, button high for tick 1 only -> tick1 OPENING h=100; tick2 h=96; tick26 h=0, gate_state=2, gate_open=1.
REQ-034 Hold/close: after OPEN, button low, x=0 -> OPEN through 120 ticks, tick 121 CLOSING h=0, 25 ticks later h=100, CLOSED, gate_open=0.
REQ-035 Zone block: counter expired with x=400 -> stays OPEN, gate_open=1 for 500 ticks; set x=451 -> next tick CLOSING.
REQ-036 Reversal: CLOSING at h=40, button high on tick -> OPENING h=40; next tick h=36; boundary x=350 and x=450 count as in_zone, x=349 does not.
REQ-037 Robustness: v_tick high 1000 clks -> height moves one STEP only; rst during OPENING at h=60 -> h=100, CLOSED next clk.
